// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared packet types, broadcast address and field helpers for the bus endpoint
// Contents:
//  PCKG_SZ   default packet width
//  pkt_t     packet type, dest_t 8-bit address type
//  BCAST     broadcast address, always accepted by every node
//  dest()    destination field [PCKG_SZ-1 -: 8]; payload() remaining low bits
package bus_pkg;

    localparam int PCKG_SZ = 16;

    typedef logic [PCKG_SZ-1:0] pkt_t;
    typedef logic [7:0]         dest_t;

    localparam dest_t BCAST = 8'hFF;

    function automatic dest_t dest(input pkt_t p);
        return p[PCKG_SZ-1 -: 8];
    endfunction

    function automatic logic [PCKG_SZ-9:0] payload(input pkt_t p);
        return p[PCKG_SZ-9:0];
    endfunction

endpackage

// File: rtl/node_fifo.sv
// rtl/node_fifo.sv - synchronous first-word-fall-through FIFO with accepted-push/pop strobes
// Ports:
//  clk, reset            clock, asynchronous active-high reset
//  push, push_data       write request and data
//  pop                   consume head request
//  full, empty           registered-state occupancy decodes
//  head                  head entry, 0 when empty
//  push_ok, pop_ok       strobes: request actually performed this cycle
module node_fifo
    import bus_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic             push_ok,
    output logic             pop_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked by empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_endpoint_node.sv
// rtl/bus_endpoint_node.sv - device-side bus endpoint: TX/RX FIFOs, destination filter, error flag and counters
// Ports:
//  clk, reset                      clock, asynchronous active-high reset
//  wr_en, wr_data, tx_full         host side of TX FIFO
//  pndng, D_pop, pop               bus side of TX FIFO (head fall-through, bus consumes)
//  push, D_push                    bus delivery into RX path
//  rd_en, rd_data, rx_empty        host side of RX FIFO
//  pop_err                         sticky: bus popped while nothing pending
//  tx_drop_cnt, rx_ovf_cnt,        saturating loss counters
//  misroute_cnt
module bus_endpoint_node
    import bus_pkg::*;
#(
    parameter int    PCKG_SZ = 16,
    parameter int    DEPTH   = 8,
    parameter dest_t ID      = 8'd0,
    parameter dest_t BCAST   = 8'hFF,
    parameter int    CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [PCKG_SZ-1:0] wr_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [PCKG_SZ-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] D_push,
    input  logic               rd_en,
    output logic [PCKG_SZ-1:0] rd_data,
    output logic               rx_empty,
    output logic               pop_err,
    output logic [CNT_W-1:0]   tx_drop_cnt,
    output logic [CNT_W-1:0]   rx_ovf_cnt,
    output logic [CNT_W-1:0]   misroute_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic  tx_empty;
    logic  tx_push_ok;
    logic  tx_pop_ok;
    logic  rx_full;
    logic  rx_push_ok;
    logic  rx_pop_ok;
    dest_t push_dest;
    logic  rx_match;
    logic  rx_push;
    logic  tx_drop;
    logic  rx_ovf;
    logic  misroute;

    node_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (D_pop),
        .push_ok   (tx_push_ok),
        .pop_ok    (tx_pop_ok)
    );

    assign pndng = ~tx_empty;

    assign push_dest = push_dest_of(D_push);
    assign rx_match  = (push_dest == ID) || (push_dest == BCAST);
    assign rx_push   = push & rx_match;

    node_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (D_push),
        .pop       (rd_en),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rd_data),
        .push_ok   (rx_push_ok),
        .pop_ok    (rx_pop_ok)
    );

    // Misrouted packets never reach the RX FIFO, so they can never also count as overflow.
    assign misroute = push & ~rx_match;
    assign rx_ovf   = rx_push & ~rx_push_ok;
    assign tx_drop  = wr_en & ~tx_push_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_err      <= 1'b0;
            tx_drop_cnt  <= '0;
            rx_ovf_cnt   <= '0;
            misroute_cnt <= '0;
        end else begin
            if (pop && tx_empty)                    pop_err      <= 1'b1;
            if (tx_drop  && tx_drop_cnt  != CNT_MAX) tx_drop_cnt  <= tx_drop_cnt  + 1'b1;
            if (rx_ovf   && rx_ovf_cnt   != CNT_MAX) rx_ovf_cnt   <= rx_ovf_cnt   + 1'b1;
            if (misroute && misroute_cnt != CNT_MAX) misroute_cnt <= misroute_cnt + 1'b1;
        end
    end

    function automatic dest_t push_dest_of(input logic [PCKG_SZ-1:0] p);
        return p[PCKG_SZ-1 -: 8];
    endfunction

endmodule

// File: tb/tb_bus_endpoint_node.sv
// tb/tb_bus_endpoint_node.sv - scoreboard bench for bus_endpoint_node
module tb_bus_endpoint_node;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        tx_full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop = 1'b0;
    logic        push = 1'b0;
    logic [15:0] D_push = '0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rx_empty;
    logic        pop_err;
    logic [7:0]  tx_drop_cnt;
    logic [7:0]  rx_ovf_cnt;
    logic [7:0]  misroute_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];

    always #5 clk = ~clk;

    bus_endpoint_node #(.PCKG_SZ(16), .DEPTH(8), .ID(8'd3), .BCAST(8'hFF), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tx_full      (tx_full),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rx_empty     (rx_empty),
        .pop_err      (pop_err),
        .tx_drop_cnt  (tx_drop_cnt),
        .rx_ovf_cnt   (rx_ovf_cnt),
        .misroute_cnt (misroute_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: whenever the bus or host consumes a head, compare it with the scoreboard.
    always @(negedge clk) begin
        if (!reset && pop && pndng) begin
            if (tx_q.size() == 0) chk("tx_unexpected_pop", 32'(D_pop), 32'hDEAD);
            else                  chk("tx_head", 32'(D_pop), 32'(tx_q.pop_front()));
        end
        if (!reset && rd_en && !rx_empty) begin
            if (rx_q.size() == 0) chk("rx_unexpected_read", 32'(rd_data), 32'hDEAD);
            else                  chk("rx_head", 32'(rd_data), 32'(rx_q.pop_front()));
        end
    end

    // One clock: inputs are applied now, sampled at the coming edge, then cleared 1 time unit after it.
    task automatic cyc(input logic w, input logic [15:0] wd, input logic p,
                       input logic ps, input logic [15:0] pd, input logic r);
        wr_en = w; wr_data = wd; pop = p; push = ps; D_push = pd; rd_en = r;
        @(posedge clk); #1;
        wr_en = 0; pop = 0; push = 0; rd_en = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        tx_q.delete();
        rx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;

        // 1) reset state
        do_reset();
        idle(5);
        chk("rst_pndng", 32'(pndng), 0);
        chk("rst_D_pop", 32'(D_pop), 0);
        chk("rst_tx_full", 32'(tx_full), 0);
        chk("rst_rx_empty", 32'(rx_empty), 1);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_pop_err", 32'(pop_err), 0);
        chk("rst_cnts", {8'h0, tx_drop_cnt, rx_ovf_cnt, misroute_cnt}, 0);

        // 2) two writes, two pops
        cyc(1, 16'h0A11, 0, 0, '0, 0); tx_q.push_back(16'h0A11);
        chk("t2_pndng_w1", 32'(pndng), 1);
        chk("t2_D_pop_w1", 32'(D_pop), 32'h0A11);
        cyc(1, 16'h0B22, 0, 0, '0, 0); tx_q.push_back(16'h0B22);
        cyc(0, '0, 1, 0, '0, 0);
        chk("t2_D_pop_p1", 32'(D_pop), 32'h0B22);
        cyc(0, '0, 1, 0, '0, 0);
        chk("t2_pndng_p2", 32'(pndng), 0);
        chk("t2_D_pop_p2", 32'(D_pop), 0);

        // 3) fill TX, drop one, then full write+pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 16'h1000 + 16'(i), 0, 0, '0, 0);
            tx_q.push_back(16'h1000 + 16'(i));
        end
        chk("t3_full", 32'(tx_full), 1);
        cyc(1, 16'h10EE, 0, 0, '0, 0);
        chk("t3_drop1", 32'(tx_drop_cnt), 1);
        cyc(1, 16'h1008, 1, 0, '0, 0); tx_q.push_back(16'h1008);
        chk("t3_drop_hold", 32'(tx_drop_cnt), 1);
        chk("t3_full_hold", 32'(tx_full), 1);
        chk("t3_head_after", 32'(D_pop), 32'h1001);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, '0, 0);
        chk("t3_drained", 32'(pndng), 0);
        chk("t3_sb_empty", 32'(tx_q.size()), 0);
        chk("t3_no_pop_err", 32'(pop_err), 0);

        // 4) address filter with ID=3
        do_reset();
        cyc(0, '0, 0, 1, 16'h0355, 0); rx_q.push_back(16'h0355);
        cyc(0, '0, 0, 1, 16'hFF66, 0); rx_q.push_back(16'hFF66);
        cyc(0, '0, 0, 1, 16'h0477, 0);
        chk("t4_misroute", 32'(misroute_cnt), 1);
        chk("t4_rd_data", 32'(rd_data), 32'h0355);
        chk("t4_ovf", 32'(rx_ovf_cnt), 0);
        cyc(0, '0, 0, 0, '0, 1);
        cyc(0, '0, 0, 0, '0, 1);
        chk("t4_rx_empty", 32'(rx_empty), 1);
        cyc(0, '0, 0, 0, '0, 1);
        chk("t4_rd_empty_ignored", 32'(rd_data), 0);

        // 5) pop_err stickiness, misroute priority, RX overflow saturation
        do_reset();
        cyc(1, 16'h2222, 1, 0, '0, 0); tx_q.push_back(16'h2222);
        chk("t5_pop_err", 32'(pop_err), 1);
        chk("t5_write_kept", 32'(D_pop), 32'h2222);
        for (int i = 0; i < 8; i++) begin
            cyc(0, '0, 0, 1, 16'h0300 + 16'(i), 0);
            rx_q.push_back(16'h0300 + 16'(i));
        end
        cyc(0, '0, 0, 1, 16'h0499, 0);
        chk("t5_misroute_prio", 32'(misroute_cnt), 1);
        chk("t5_ovf_zero", 32'(rx_ovf_cnt), 0);
        for (int i = 8; i < 262; i++) cyc(0, '0, 0, 1, 16'h03AA, 0);
        chk("t5_ovf_254", 32'(rx_ovf_cnt), 254);
        for (int i = 262; i < 300; i++) cyc(0, '0, 0, 1, 16'h03AA, 0);
        chk("t5_ovf_sat", 32'(rx_ovf_cnt), 255);
        cyc(0, '0, 0, 1, 16'h03BB, 1); rx_q.push_back(16'h03BB);
        chk("t5_ovf_hold", 32'(rx_ovf_cnt), 255);
        for (int i = 0; i < 8; i++) cyc(0, '0, 0, 0, '0, 1);
        chk("t5_rx_drained", 32'(rx_empty), 1);
        chk("t5_rx_sb_empty", 32'(rx_q.size()), 0);
        chk("t5_pop_err_held", 32'(pop_err), 1);

        // 6) asynchronous reset with TX traffic queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 16'h3300 + 16'(i), 0, 0, '0, 0);
            tx_q.push_back(16'h3300 + 16'(i));
        end
        chk("t6_pre_head", 32'(D_pop), 32'h3300);
        #2 reset = 1;
        #1;
        chk("t6_async_pndng", 32'(pndng), 0);
        chk("t6_async_D_pop", 32'(D_pop), 0);
        tx_q.delete();
        rx_q.delete();
        @(posedge clk); #1;
        reset = 0;
        cyc(1, 16'hBEEF, 0, 0, '0, 0); tx_q.push_back(16'hBEEF);
        chk("t6_restart_head", 32'(D_pop), 32'hBEEF);
        chk("t6_restart_pndng", 32'(pndng), 1);
        chk("t6_pop_err_clear", 32'(pop_err), 0);
        cyc(0, '0, 1, 0, '0, 0);
        chk("t6_final_empty", 32'(pndng), 0);
        chk("t6_sb_empty", 32'(tx_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
